// File: rtl/dm_access_stage.sv
// Data-memory access stage: turns ld/st held in DM into req/ack bus transactions and freezes the pipe meanwhile.
// Optional DM_TIMEOUT_EN adds a bounded ACCESS wait that completes with ERR_DATA and a dm_err pulse.
module dm_access_stage #(
  parameter int          ADDR_W   = 12,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_DM,
  input  logic              is_Ld_DM,
  input  logic              is_St_DM,
  input  logic [31:0]       aluResult_DM,
  input  logic [31:0]       op2_DM,
  output logic              stall_DM,
  output logic [31:0]       DMResult_DM,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [31:0]       memWdata_q;
  logic [31:0]       result_q;
  logic              acc;
  logic              isStore;
  logic              unusedAddrBits;

  assign acc            = valid_DM & (is_Ld_DM | is_St_DM);
  assign isStore        = is_St_DM & ~is_Ld_DM;
  assign unusedAddrBits = ^aluResult_DM;

  // DONE releases the stall for one cycle so the finished instruction moves on to DM/WB.
  assign stall_DM = rst_n & ((state_q == IDLE) ? acc : (state_q == ACCESS));

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             dmErr_q;
  logic             expire;

  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign dm_err = dmErr_q;
`else
  logic [31:0] unusedCfg;

  assign unusedCfg = ERR_DATA ^ 32'(TIMEOUT);
  assign dm_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      result_q   <= '0;
`ifdef DM_TIMEOUT_EN
      cnt_q      <= '0;
      dmErr_q    <= 1'b0;
`endif
    end else begin
`ifdef DM_TIMEOUT_EN
      dmErr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (acc) begin
            memReq_q   <= 1'b1;
            memWe_q    <= isStore;
            memAddr_q  <= aluResult_DM[ADDR_W+1:2];
            memWdata_q <= op2_DM;
`ifdef DM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack coinciding with expiry takes priority and completes normally.
          if (mem_ack) begin
            memReq_q <= 1'b0;
            if (!memWe_q) begin
              result_q <= mem_rdata;
            end
            state_q <= DONE;
          end
`ifdef DM_TIMEOUT_EN
          else if (expire) begin
            memReq_q <= 1'b0;
            if (!memWe_q) begin
              result_q <= ERR_DATA;
            end
            dmErr_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = memReq_q;
  assign mem_we      = memWe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign DMResult_DM = result_q;

endmodule

// File: tb/tb_dm_access_stage.sv
// Bench for dm_access_stage: a variable-latency memory responder plus a word-array reference model of ld/st effects.
// Define DM_TIMEOUT_EN for both files to exercise the timeout path (TIMEOUT is overridden to 8 here).
module tb_dm_access_stage;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        valid_DM;
  logic        is_Ld_DM;
  logic        is_St_DM;
  logic [31:0] aluResult_DM;
  logic [31:0] op2_DM;
  logic        stall_DM;
  logic [31:0] DMResult_DM;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] memArr [0:4095];
  logic [31:0] refMem [0:4095];
  txn_t        txnLog [$];
  int          ackDelay;
  int          total;
  int          bad;
  logic [31:0] lastResult;

  dm_access_stage #(.ADDR_W(12), .TIMEOUT(TB_TIMEOUT), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .valid_DM(valid_DM), .is_Ld_DM(is_Ld_DM), .is_St_DM(is_St_DM),
    .aluResult_DM(aluResult_DM), .op2_DM(op2_DM), .stall_DM(stall_DM), .DMResult_DM(DMResult_DM),
    .dm_err(dm_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory side: acks ackDelay cycles after the first ACCESS cycle and checks the request stays stable.
  initial begin : responder
    bit   busy;
    int   waitLeft;
    txn_t cur;
    busy = 0;
    waitLeft = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        busy = 0;
      end else if (busy && !mem_req) begin
        busy = 0;
      end else if (busy || mem_req) begin
        if (!busy) begin
          busy = 1;
          cur.we = mem_we;
          cur.addr = mem_addr;
          cur.wdata = mem_wdata;
          waitLeft = ackDelay;
        end else begin
          checkOutput("reqHeld", 32'(mem_req), 32'd1);
          checkOutput("weHeld", 32'(mem_we), 32'(cur.we));
          checkOutput("addrHeld", 32'(mem_addr), 32'(cur.addr));
          checkOutput("wdataHeld", mem_wdata, cur.wdata);
        end
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          if (cur.we) memArr[cur.addr] = cur.wdata;
          else mem_rdata = memArr[cur.addr];
          txnLog.push_back(cur);
        end else begin
          waitLeft--;
        end
      end
    end
  end

  // Drives one instruction (called just after a negedge) and waits until the pipeline lets it advance.
  task automatic applyStimulus(input logic v, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [31:0] data, input int delay);
    bit          isMem;
    bit          we;
    bit          timedOut;
    int          expStalls;
    int          stalls;
    logic [11:0] idx;
    txn_t        t;
    isMem = v && (ld || st);
    we = st && !ld;
    idx = addr[13:2];
    timedOut = 0;
`ifdef DM_TIMEOUT_EN
    timedOut = isMem && (delay >= TB_TIMEOUT);
`endif
    expStalls = !isMem ? 0 : (timedOut ? TB_TIMEOUT + 1 : delay + 2);
    if (isMem && !we) lastResult = timedOut ? 32'hDEADBEEF : refMem[idx];
    if (isMem && we && !timedOut) refMem[idx] = data;

    ackDelay = delay;
    valid_DM = v;
    is_Ld_DM = ld;
    is_St_DM = st;
    aluResult_DM = addr;
    op2_DM = data;
    #1;
    checkOutput("errIdle", 32'(dm_err), 32'd0);
    stalls = 0;
    while (stall_DM && stalls < 300) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checkOutput("stalls", 32'(stalls), 32'(expStalls));
    checkOutput("result", DMResult_DM, lastResult);
    checkOutput("dmErr", 32'(dm_err), 32'(timedOut));
    checkOutput("reqDone", 32'(mem_req), 32'd0);
    if (isMem && !timedOut) begin
      checkOutput("txnCount", 32'(txnLog.size()), 32'd1);
      if (txnLog.size() > 0) begin
        t = txnLog.pop_front();
        checkOutput("txnWe", 32'(t.we), 32'(we));
        checkOutput("txnAddr", 32'(t.addr), 32'(idx));
        if (we) checkOutput("txnWdata", t.wdata, data);
      end
    end else begin
      checkOutput("txnCount", 32'(txnLog.size()), 32'd0);
    end
    txnLog.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int          kind;
    int          maxDelay;
    total = 0;
    bad = 0;
    lastResult = '0;
    ackDelay = 0;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      memArr[i] = w;
      refMem[i] = w;
    end
    memArr[4] = 32'h1234_5678;
    refMem[4] = 32'h1234_5678;

    rst_n = 1'b0;
    valid_DM = 1'b1;
    is_Ld_DM = 1'b1;
    is_St_DM = 1'b0;
    aluResult_DM = 32'h0000_0123;
    op2_DM = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstStall", 32'(stall_DM), 32'd0);
    checkOutput("rstReq", 32'(mem_req), 32'd0);
    checkOutput("rstAddr", 32'(mem_addr), 32'd0);
    checkOutput("rstResult", DMResult_DM, 32'd0);
    checkOutput("rstErr", 32'(dm_err), 32'd0);
    valid_DM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0040, 32'hCAFE_F00D, 3);
    applyStimulus(1, 1, 0, 32'h0000_0043, 32'h0, 1);
    applyStimulus(1, 0, 1, 32'h0000_0104, 32'h0BAD_F00D, 0);
    applyStimulus(1, 1, 1, 32'h0000_0104, 32'h1111_2222, 2);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, $urandom, $urandom, 0);
    applyStimulus(0, 1, 0, 32'h0000_0010, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0010, 32'h7777_7777, 0);

    // Reset in the middle of a long ACCESS abandons the load.
    ackDelay = 50;
    valid_DM = 1'b1;
    is_Ld_DM = 1'b1;
    is_St_DM = 1'b0;
    aluResult_DM = 32'h0000_0200;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("preRstReq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", 32'(mem_req), 32'd0);
    checkOutput("midRstStall", 32'(stall_DM), 32'd0);
    checkOutput("midRstResult", DMResult_DM, 32'd0);
    lastResult = '0;
    valid_DM = 1'b0;
    txnLog.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0, 1);

`ifdef DM_TIMEOUT_EN
    applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0, 20);
    applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0, TB_TIMEOUT - 1);
    applyStimulus(1, 0, 1, 32'h0000_0020, 32'hABCD_0123, 20);
    applyStimulus(1, 1, 0, 32'h0000_0020, 32'h0, 0);
    maxDelay = 10;
`else
    maxDelay = 6;
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: applyStimulus(1, 0, 0, $urandom, $urandom, 0);
        1: applyStimulus(0, 1'($urandom), 1'($urandom), $urandom, $urandom, 0);
        2, 3: applyStimulus(1, 1, 0, $urandom, $urandom, $urandom_range(0, maxDelay));
        4: applyStimulus(1, 0, 1, $urandom, $urandom, $urandom_range(0, maxDelay));
        default: applyStimulus(1, 1, 1, $urandom, $urandom, $urandom_range(0, maxDelay));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_access_stage.md
Name: dm_access_stage

Overview:
- Data-memory access stage of the SimpleRISC 5-stage pipeline. Sits between the EX/DM pipe register and the DM/WB pipe register.
- Turns ld/st instructions held in DM into request/acknowledge transactions on a variable-latency data-memory bus.
- Freezes the upstream pipeline until each transaction completes.
- Presents load data as DMResult_DM to the DM/WB pipe register.

Parameters:
- ADDR_W, 12, word-address width of the data-memory bus.
- TIMEOUT, 255, max cycles waiting for mem_ack (used only with DM_TIMEOUT_EN).
- ERR_DATA, 32'hDEADBEEF, load data returned on timeout.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_DM  in  1  DM stage holds a real instruction (0 = bubble).
- is_Ld_DM  in  1  instruction is ld.
- is_St_DM  in  1  instruction is st.
- aluResult_DM  in  32  effective byte address from EX.
- op2_DM  in  32  store data (rd value).
- stall_DM  out  1  freeze PC, IF/OF, OF/EX, EX/DM pipes; drives stall_DMWB.
- DMResult_DM  out  32  last load data, to DM/WB pipe.
- dm_err  out  1  one-cycle pulse on transaction timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, DMResult_DM=0, dm_err=0, timeout counter=0. stall_DM=0 while in reset.
- acc = valid_DM & (is_Ld_DM | is_St_DM). If is_Ld_DM and is_St_DM are both set, treat as ld.
- FSM, 3 states:
  - IDLE:
    - stall_DM = acc (combinational).
    - If acc: register mem_req=1, mem_we=is_St_DM & ~is_Ld_DM, mem_addr=aluResult_DM[ADDR_W+1:2], mem_wdata=op2_DM; go to ACCESS.
    - Otherwise stay in IDLE; non-memory instructions pass with no stall.
  - ACCESS:
    - stall_DM=1.
    - mem_req and its address/we/wdata held stable until the cycle mem_ack=1.
    - On ack: mem_req deasserts next edge. For a load, DMResult_DM <= mem_rdata; for a store, DMResult_DM unchanged. Go to DONE.
  - DONE:
    - stall_DM=0 for exactly one cycle, so the completed instruction advances into DM/WB at the end of this cycle.
    - Must not retrigger on the same instruction. Go to IDLE.
- Latency: a memory op occupies DM for 2+N cycles, where N = ack wait (N≥1; ack in the first ACCESS cycle gives the 3-cycle minimum). Back-to-back ld/st are handled with no lost or duplicated access.
- aluResult_DM[1:0] are ignored (word access only).
- mem_ack outside ACCESS is ignored.
- DMResult_DM is a register that holds its value between loads. WB selects it using is_Ld_WB.
- Reset asserted mid-ACCESS: mem_req drops immediately and the transaction is abandoned. The memory must tolerate an abandoned request.

Optional Feature:
- Macro DM_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT with no ack: drop mem_req, DMResult_DM <= ERR_DATA (loads only), dm_err=1 for one cycle, go to DONE.
  - An ack arriving in the same cycle as expiry wins: normal completion, no dm_err.
- Undefined: no counter; ACCESS waits indefinitely; dm_err tied to 0.

Test Plan:
- Ld at aluResult_DM=32'h0000_0010, memory word 4 = 32'h1234_5678, ack in first ACCESS cycle -> mem_addr=4, mem_we=0; stall_DM high 2 cycles then low 1; DMResult_DM=32'h1234_5678 in DONE.
- St op2_DM=32'hCAFE_F00D at address 32'h40, ack after 3 wait cycles -> mem_we=1, mem_addr=16, mem_wdata held stable 4 cycles; stall_DM high 5 cycles; DMResult_DM unchanged.
- Ld then st back-to-back -> exactly two mem_req transactions, in order; load data captured; no extra stall between them beyond DONE.
- Stream of add/sub with valid_DM=1 and no ld/st -> stall_DM stays 0; mem_req never asserted.
- rst_n pulled low during ACCESS -> mem_req=0 immediately, stall_DM=0, DMResult_DM=0; after release, the next ld completes normally.
- With DM_TIMEOUT_EN, TIMEOUT=8, ld with no ack -> mem_req drops after 8 ACCESS cycles, dm_err one-cycle pulse, DMResult_DM=32'hDEADBEEF; with ack in the 8th cycle, real data returned and dm_err=0.
